// File: rtl/merge_select_arbiter_if.sv
// Request, select-token and status signals of the two-input merge scheduler.
// master: requesters / S bridge / merge side; slave: the scheduler itself.
interface merge_select_arbiter_if #(
    parameter int unsigned LEN_W = 4
);
    logic             req0_valid;
    logic [LEN_W-1:0] req0_len;
    logic             req0_ack;
    logic             req1_valid;
    logic [LEN_W-1:0] req1_len;
    logic             req1_ack;
    logic             s_valid;
    logic             s_data;
    logic             s_ready;
    logic             flit_done;
    logic             busy;
    logic             grant_id;
    logic             err;

    modport master (
        output req0_valid, req0_len, req1_valid, req1_len, s_ready, flit_done,
        input  req0_ack, req1_ack, s_valid, s_data, busy, grant_id, err
    );

    modport slave (
        input  req0_valid, req0_len, req1_valid, req1_len, s_ready, flit_done,
        output req0_ack, req1_ack, s_valid, s_data, busy, grant_id, err
    );
endinterface

// File: rtl/merge_select_arbiter.sv
// Round-robin packet scheduler for a 2-input NoC merge: grants one input,
// issues a select token, then holds the grant until len+1 flits complete.
module merge_select_arbiter #(
    parameter int unsigned LEN_W = 4
) (
    input logic                   CLK,
    input logic                   RESET,
    merge_select_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t           state;
    logic             prio;
    logic             grant_id;
    logic [LEN_W-1:0] cnt;
    logic             err;
    logic             s_valid;
    logic             ack0;
    logic             ack1;
    logic             busy;

    logic             winner;
    logic [LEN_W-1:0] win_len;
    logic             any_req;

    // Winner selection: a lone requester wins, contention is settled by prio.
    always_comb begin
        winner  = 1'b0;
        any_req = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = prio;
        end else begin
            winner = bus.req1_valid;
        end
        win_len = winner ? bus.req1_len : bus.req0_len;
    end

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            prio     <= 1'b0;
            grant_id <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
            s_valid  <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flit_done) begin
                        err <= 1'b1;
                    end
                    if (any_req) begin
                        grant_id <= winner;
                        cnt      <= win_len;
                        ack0     <= ~winner;
                        ack1     <= winner;
                        s_valid  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.flit_done) begin
                        err <= 1'b1;
                    end
                    if (bus.s_ready) begin
                        s_valid <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flit_done) begin
                        if (cnt == '0) begin
                            prio  <= ~grant_id;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    s_valid <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ack = ack0;
    assign bus.req1_ack = ack1;
    assign bus.s_valid  = s_valid;
    assign bus.s_data   = grant_id;
    assign bus.busy     = busy;
    assign bus.grant_id = grant_id;
    assign bus.err      = err;
endmodule

// File: tb/tb_merge_select_arbiter.sv
// Directed bench for merge_select_arbiter: inputs driven and outputs checked
// on the falling clock edge, expected values written out by hand.
module tb_merge_select_arbiter;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    merge_select_arbiter_if #(.LEN_W(4)) bus ();

    merge_select_arbiter #(.LEN_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        RESET          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_len   = 4'd0;
        bus.req1_len   = 4'd0;
        bus.s_ready    = 1'b0;
        bus.flit_done  = 1'b0;

        // Reset held two cycles with both requests pending
        tick();
        tick();
        chk("rst_s_valid", 8'(bus.s_valid), 8'd0);
        chk("rst_ack0", 8'(bus.req0_ack), 8'd0);
        chk("rst_ack1", 8'(bus.req1_ack), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_err", 8'(bus.err), 8'd0);
        chk("rst_grant", 8'(bus.grant_id), 8'd0);

        // Contention: In0 wins first (prio 0), then alternation
        RESET        = 1'b0;
        bus.req0_len = 4'd2;
        bus.req1_len = 4'd0;
        bus.s_ready  = 1'b1;
        tick();
        chk("c1_s_valid", 8'(bus.s_valid), 8'd1);
        chk("c1_s_data", 8'(bus.s_data), 8'd0);
        chk("c1_ack0", 8'(bus.req0_ack), 8'd1);
        chk("c1_ack1", 8'(bus.req1_ack), 8'd0);
        chk("c1_busy", 8'(bus.busy), 8'd1);
        chk("c1_grant", 8'(bus.grant_id), 8'd0);
        tick();
        chk("c1_busy_s_valid", 8'(bus.s_valid), 8'd0);
        chk("c1_ack0_pulse", 8'(bus.req0_ack), 8'd0);
        chk("c1_busy_state", 8'(bus.busy), 8'd1);
        bus.flit_done = 1'b1;
        tick();
        tick();
        chk("c1_two_flits_hold", 8'(bus.busy), 8'd1);
        tick();
        bus.flit_done = 1'b0;
        chk("c1_release", 8'(bus.busy), 8'd0);
        chk("c1_idle_s_valid", 8'(bus.s_valid), 8'd0);
        chk("c1_grant_hold", 8'(bus.grant_id), 8'd0);
        tick();
        chk("c2_s_valid", 8'(bus.s_valid), 8'd1);
        chk("c2_s_data", 8'(bus.s_data), 8'd1);
        chk("c2_ack1", 8'(bus.req1_ack), 8'd1);
        chk("c2_ack0", 8'(bus.req0_ack), 8'd0);
        chk("c2_grant", 8'(bus.grant_id), 8'd1);
        tick();
        chk("c2_busy", 8'(bus.busy), 8'd1);
        chk("c2_busy_s_valid", 8'(bus.s_valid), 8'd0);
        bus.flit_done = 1'b1;
        tick();
        bus.flit_done = 1'b0;
        chk("c2_release", 8'(bus.busy), 8'd0);
        tick();
        chk("c3_s_valid", 8'(bus.s_valid), 8'd1);
        chk("c3_s_data", 8'(bus.s_data), 8'd0);
        chk("c3_ack0", 8'(bus.req0_ack), 8'd1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        bus.flit_done = 1'b1;
        tick();
        tick();
        tick();
        bus.flit_done = 1'b0;
        chk("c3_release", 8'(bus.busy), 8'd0);

        // Backpressure on In1: token held five cycles, single ack
        bus.req1_len   = 4'd1;
        bus.req1_valid = 1'b1;
        bus.s_ready    = 1'b0;
        tick();
        chk("bp_s_valid", 8'(bus.s_valid), 8'd1);
        chk("bp_s_data", 8'(bus.s_data), 8'd1);
        chk("bp_ack1", 8'(bus.req1_ack), 8'd1);
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_s_valid", 8'(bus.s_valid), 8'd1);
            chk("bp_hold_s_data", 8'(bus.s_data), 8'd1);
            chk("bp_hold_ack1", 8'(bus.req1_ack), 8'd0);
            chk("bp_hold_busy", 8'(bus.busy), 8'd1);
        end
        bus.s_ready = 1'b1;
        tick();
        chk("bp_accept_s_valid", 8'(bus.s_valid), 8'd0);
        chk("bp_accept_busy", 8'(bus.busy), 8'd1);
        bus.flit_done = 1'b1;
        tick();
        chk("bp_first_flit_hold", 8'(bus.busy), 8'd1);
        tick();
        bus.flit_done = 1'b0;
        chk("bp_release", 8'(bus.busy), 8'd0);

        // Maximum length: 16 flits, the 15th must not release
        bus.req0_len   = 4'hF;
        bus.req0_valid = 1'b1;
        tick();
        chk("max_ack0", 8'(bus.req0_ack), 8'd1);
        chk("max_s_data", 8'(bus.s_data), 8'd0);
        bus.req0_valid = 1'b0;
        tick();
        bus.flit_done = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("max_15th_holds", 8'(bus.busy), 8'd1);
        tick();
        bus.flit_done = 1'b0;
        chk("max_16th_release", 8'(bus.busy), 8'd0);

        // Spurious flit_done in IDLE and in ISSUE
        chk("sp_err_clear", 8'(bus.err), 8'd0);
        bus.flit_done = 1'b1;
        tick();
        bus.flit_done = 1'b0;
        chk("sp_err_set", 8'(bus.err), 8'd1);
        chk("sp_idle_busy", 8'(bus.busy), 8'd0);
        chk("sp_idle_s_valid", 8'(bus.s_valid), 8'd0);
        tick();
        chk("sp_err_sticky", 8'(bus.err), 8'd1);
        bus.req0_len   = 4'd0;
        bus.req0_valid = 1'b1;
        tick();
        chk("sp_s_valid", 8'(bus.s_valid), 8'd1);
        chk("sp_s_data", 8'(bus.s_data), 8'd0);
        chk("sp_ack0", 8'(bus.req0_ack), 8'd1);
        bus.req0_valid = 1'b0;
        bus.flit_done  = 1'b1;
        tick();
        bus.flit_done = 1'b0;
        chk("sp_issue_flit_ignored", 8'(bus.busy), 8'd1);
        chk("sp_err_still", 8'(bus.err), 8'd1);
        tick();
        chk("sp_waiting", 8'(bus.busy), 8'd1);
        bus.flit_done = 1'b1;
        tick();
        bus.flit_done = 1'b0;
        chk("sp_release", 8'(bus.busy), 8'd0);

        // Mid-packet reset with cnt=3 and prio=1 pending
        bus.req1_len   = 4'd3;
        bus.req1_valid = 1'b1;
        tick();
        chk("mr_s_data", 8'(bus.s_data), 8'd1);
        bus.req1_valid = 1'b0;
        tick();
        chk("mr_busy", 8'(bus.busy), 8'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mr_rst_busy", 8'(bus.busy), 8'd0);
        chk("mr_rst_s_valid", 8'(bus.s_valid), 8'd0);
        chk("mr_rst_grant", 8'(bus.grant_id), 8'd0);
        chk("mr_rst_err", 8'(bus.err), 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_token", 8'(bus.s_valid), 8'd0);
            chk("mr_idle", 8'(bus.busy), 8'd0);
        end
        bus.req0_len   = 4'd0;
        bus.req1_len   = 4'd0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        chk("mr_prio0_s_data", 8'(bus.s_data), 8'd0);
        chk("mr_prio0_ack0", 8'(bus.req0_ack), 8'd1);
        chk("mr_prio0_ack1", 8'(bus.req1_ack), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
